// File: rtl/rep_code_tx_pkg.sv
// ----------------------------------------------------------------------------
// rep_code_tx_pkg
//   Definitions shared by the repetition-code transmitter and the matching
//   majority-voter receiver: FSM state encoding, default code parameters and
//   a counter-width helper.
// ----------------------------------------------------------------------------
package rep_code_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int DEF_REP    = 5;
    localparam int DEF_DATA_W = 8;

    // Bits needed to count 0..n-1. Never returns less than 1 so that a
    // modulus of 1 still yields a legal vector width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rep_code_tx_if.sv
// ----------------------------------------------------------------------------
// rep_code_tx_if
//   Handshake bundle of the repetition-code transmitter.
//   in_data/in_valid/in_ready : parallel word input (valid/ready)
//   tx_bit/tx_valid/tx_ready  : serial code-bit output (valid/ready)
//   tx_first/tx_last          : frame markers on the serial output
//   busy                      : a word is loaded and not yet fully sent
//   master : the environment (word source + serial sink)
//   slave  : the transmitter
// ----------------------------------------------------------------------------
interface rep_code_tx_if
    import rep_code_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_bit;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_first;
    logic              tx_last;
    logic              busy;

    modport master (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_bit, tx_valid, tx_first, tx_last, busy
    );

    modport slave (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_bit, tx_valid, tx_first, tx_last, busy
    );

endinterface

// File: rtl/rep_code_tx_mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
//   Modulo-MOD up counter with synchronous clear and count enable.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, counter to 0
//   clr  : synchronous clear, wins over en
//   en   : advance by one
//   cnt  : current count, 0..MOD-1
//   wrap : combinational, high when en is set and cnt is at MOD-1
// ----------------------------------------------------------------------------
module mod_counter
    import rep_code_tx_pkg::*;
#(
    parameter int MOD = DEF_REP,
    parameter int W   = clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Terminal count is compared explicitly so non-power-of-two moduli work.
    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rep_code_tx.sv
// ----------------------------------------------------------------------------
// rep_code_tx
//   Transmit side of an odd-length repetition code. A parallel word is
//   serialised LSB first and each data bit is sent REP times on consecutive
//   beats, so a downstream majority voter survives (REP-1)/2 corrupted copies
//   per bit. Zero-bubble back-to-back words are supported: a new word may be
//   accepted on the final beat of the current one.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; discards any word in flight
//   bus : rep_code_tx_if slave port (word input, serial output, busy)
// ----------------------------------------------------------------------------
module rep_code_tx
    import rep_code_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REP    = DEF_REP
) (
    input  logic         clk,
    input  logic         rst,
    rep_code_tx_if.slave bus
);

    localparam int RW = clog2(REP);
    localparam int BW = clog2(DATA_W);

    localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    if (REP < 3 || (REP % 2) == 0) begin : g_bad_rep
        $error("rep_code_tx: REP must be odd and >= 3");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("rep_code_tx: DATA_W must be in 1..32");
    end

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [RW-1:0]     rep_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              send;
    logic              beat;
    logic              accept;
    logic              rep_wrap;
    logic              word_done;

    assign send   = (state == ST_SEND);
    assign beat   = send & bus.tx_ready;
    assign accept = bus.in_valid & bus.in_ready;

    // Copy counter advances on every beat; clearing on accept restarts a
    // frame even when the accept coincides with the last beat.
    mod_counter #(
        .MOD (REP),
        .W   (RW)
    ) u_rep_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (beat),
        .cnt  (rep_cnt),
        .wrap (rep_wrap)
    );

    // Bit counter advances once per REP beats. Its wrap is exactly the
    // final beat of the word (a beat with tx_last set).
    mod_counter #(
        .MOD (DATA_W),
        .W   (BW)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (rep_wrap),
        .cnt  (bit_cnt),
        .wrap (word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift only after the last copy of a bit so tx_bit is stable across
    // stalls and across the REP copies of one bit. Zero fill leaves the
    // register clear once a word has been fully sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= bus.in_data;
        end else if (rep_wrap) begin
            shreg <= shreg >> 1;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.tx_first = 1'b0;
        bus.tx_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // Ready on the last beat allows zero-bubble word chaining;
                // this path is combinational from tx_ready.
                bus.in_ready = word_done;
                bus.tx_first = (bit_cnt == '0) && (rep_cnt == '0);
                bus.tx_last  = (bit_cnt == BIT_LAST) && (rep_cnt == REP_LAST);
                if (word_done && !accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.tx_bit   = shreg[0];
    assign bus.tx_valid = send;
    assign bus.busy     = send;

endmodule

// File: tb/tb_rep_code_tx.sv
// ----------------------------------------------------------------------------
// tb_rep_code_tx
//   Directed bench for rep_code_tx (DATA_W=8, REP=5): reset state, single
//   word, back-to-back words, stalls, mid-word reset, majority-vote loopback
//   with corrupted copies, and in_valid held while busy.
// ----------------------------------------------------------------------------
module tb_rep_code_tx;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    rep_code_tx_if #(.DATA_W(8)) bus ();

    rep_code_tx #(
        .DATA_W (8),
        .REP    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a word while idle; the accept happens on the next rising edge.
    task automatic drive_accept(input logic [7:0] w);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.tx_ready = 1'b1;
        #1;
        chk("accept_in_ready", bus.in_ready, 1);
        chk("accept_idle_tx_valid", bus.tx_valid, 0);
    endtask

    // Follow one word already accepted. Each bit w[i] must appear on beats
    // 5i..5i+4. Optional stall (tx_ready low) at stall_beat for stall_len
    // cycles, optional early exit at abort_beat, optional in_valid held with
    // changing data during the word, and optional next word on the last beat.
    task automatic expect_word(input logic [7:0] w, input int stall_beat, input int stall_len,
                               input int abort_beat, input bit mid_valid, input bit nv,
                               input logic [7:0] nw);
        int beat;
        int cyc;
        int stalled;
        bit stall;
        beat    = 0;
        cyc     = 0;
        stalled = 0;
        while (beat < 40 && beat != abort_beat && cyc < 300) begin
            @(negedge clk);
            cyc++;
            stall = (beat == stall_beat) && (stalled < stall_len);
            bus.tx_ready = !stall;
            if (beat == 39 && !stall) begin
                bus.in_valid = nv;
                bus.in_data  = nw;
            end else begin
                bus.in_valid = mid_valid;
                bus.in_data  = mid_valid ? 8'($urandom) : w;
            end
            #1;
            chk("word_tx_valid", bus.tx_valid, 1);
            chk("word_busy", bus.busy, 1);
            chk("word_tx_bit", bus.tx_bit, w[beat / 5]);
            chk("word_tx_first", bus.tx_first, (beat == 0));
            chk("word_tx_last", bus.tx_last, (beat == 39));
            chk("word_in_ready", bus.in_ready, (beat == 39 && !stall));
            if (stall) stalled++;
            else beat++;
        end
        if (abort_beat < 0) chk("word_beat_count", beat, 40);
    endtask

    task automatic expect_idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.tx_ready = 1'b1;
        #1;
        chk("idle_tx_valid", bus.tx_valid, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_tx_first", bus.tx_first, 0);
        chk("idle_tx_last", bus.tx_last, 0);
        chk("idle_tx_bit", bus.tx_bit, 0);
    endtask

    initial begin
        logic [7:0] word;
        logic [7:0] rec;
        int         beat;
        int         cyc;
        int         ones;
        int         fa;
        int         fb;
        int         r;

        errs         = 0;
        checks       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.tx_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_bit", bus.tx_bit, 0);
        chk("rst_tx_first", bus.tx_first, 0);
        chk("rst_tx_last", bus.tx_last, 0);
        rst = 1'b0;
        expect_idle();

        // Single word A5: 11111 00000 11111 00000 00000 11111 00000 11111
        drive_accept(8'hA5);
        expect_word(8'hA5, -1, 0, -1, 1'b0, 1'b0, 8'h00);
        expect_idle();

        // Back-to-back FF then 00 with no bubble
        drive_accept(8'hFF);
        expect_word(8'hFF, -1, 0, -1, 1'b0, 1'b1, 8'h00);
        expect_word(8'h00, -1, 0, -1, 1'b0, 1'b0, 8'h00);
        expect_idle();

        // Word 01 with a 3-cycle stall at beat 2
        drive_accept(8'h01);
        expect_word(8'h01, 2, 3, -1, 1'b0, 1'b0, 8'h00);
        expect_idle();

        // Reset at beat 17 of 3C, then 81 starts cleanly
        drive_accept(8'h3C);
        expect_word(8'h3C, -1, 0, 17, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", bus.tx_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_tx_first", bus.tx_first, 0);
        chk("midrst_tx_bit", bus.tx_bit, 0);
        @(negedge clk);
        rst = 1'b0;
        expect_idle();
        drive_accept(8'h81);
        expect_word(8'h81, -1, 0, -1, 1'b0, 1'b0, 8'h00);
        expect_idle();

        // in_valid held with changing data mid-word; C3 taken on the last beat
        drive_accept(8'h5A);
        expect_word(8'h5A, 10, 2, -1, 1'b1, 1'b1, 8'hC3);
        expect_word(8'hC3, -1, 0, -1, 1'b0, 1'b0, 8'h00);
        expect_idle();

        // Loopback through a 3-of-5 voter with 2 copies per bit flipped
        for (int n = 0; n < 200; n++) begin
            word = 8'($urandom);
            drive_accept(word);
            rec  = '0;
            beat = 0;
            cyc  = 0;
            ones = 0;
            fa   = 0;
            fb   = 0;
            while (beat < 40 && cyc < 300) begin
                @(negedge clk);
                cyc++;
                bus.in_valid = 1'b0;
                bus.tx_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (bus.tx_valid && bus.tx_ready) begin
                    r = beat % 5;
                    if (r == 0) begin
                        fa   = int'($urandom_range(0, 4));
                        fb   = (fa + int'($urandom_range(1, 4))) % 5;
                        ones = 0;
                    end
                    ones += int'(bus.tx_bit ^ ((r == fa) || (r == fb)));
                    if (r == 4) rec[beat / 5] = (ones >= 3);
                    beat++;
                end
            end
            chk("loop_beat_count", beat, 40);
            chk("loop_word", rec, word);
        end
        expect_idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
